// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS EX-stage helpers:
//   - ALU control codes driven onto the ALU's control input
//   - HI/LO multiply/divide operation encodings
//   - state encoding of the multiply/divide sequencer
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_SIGN = 3'd1,
        MD_ITER = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

    // Bit 1 of the op selects divide, bit 0 selects the signed variant.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/twos_negate.sv
// ---------------------------------------------------------------------------
// twos_negate
// Combinational two's-complement negation, y = -a (mod 2^W).
// Ports:
//   a_i  in  W  value to negate
//   y_o  out W  negated value
// ---------------------------------------------------------------------------
module twos_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    assign y_o = ~a_i + W'(1);

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle MULT/MULTU/DIV/DIVU controller. Runs DATA_W shift-add
// (multiply) or shift-subtract (restoring divide) iterations through an
// externally instantiated ALU, then writes HI/LO.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   start       in   launch request, sampled only in IDLE
//   op          in   2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rsdata      in   DATA_W multiplicand / dividend
//   rtdata      in   DATA_W multiplier / divisor
//   busy        out  high in SIGN, ITER, FIX
//   done        out  one-cycle pulse, hi/lo valid
//   hi, lo      out  DATA_W result registers
//   alu_a       out  DATA_W ALU operand A
//   alu_b       out  DATA_W ALU operand B
//   alu_ctrl    out  4  ALU control (ADD/SUB)
//   alu_result  in   DATA_W result from the owned ALU
// ---------------------------------------------------------------------------
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rsdata,
    input  logic [DATA_W-1:0] rtdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    md_state_e         state_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] rs_q, rt_q;
    logic [DATA_W-1:0] opb_q;     // multiplicand (mult) or divisor (div)
    logic [DATA_W-1:0] acc_q;     // P_hi (mult) or remainder R (div)
    logic [DATA_W-1:0] sh_q;      // P_lo (mult) or quotient Q (div)
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              negq_q, negr_q, div0_q;
    logic              busy_q, done_q;

    logic [DATA_W-1:0] acc_d, sh_d;
    logic [DATA_W-1:0] rem_shift;
    logic              carry, borrow;
    logic              op_signed, op_div;

    assign op_signed = md_is_signed(op_q);
    assign op_div    = md_is_div(op_q);

    // Absolute values of the latched operands, formed locally so the ALU
    // stays free for the iteration datapath.
    logic [DATA_W-1:0] opnd     [2];
    logic [DATA_W-1:0] opnd_neg [2];
    logic [DATA_W-1:0] opnd_abs [2];

    assign opnd[0] = rs_q;
    assign opnd[1] = rt_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            twos_negate #(.W(DATA_W)) u_neg (
                .a_i (opnd[gi]),
                .y_o (opnd_neg[gi])
            );
            assign opnd_abs[gi] = (op_signed && opnd[gi][DATA_W-1]) ? opnd_neg[gi] : opnd[gi];
        end
    endgenerate

    // Sign fix-up negators used in FIX.
    logic [2*DATA_W-1:0] prod_neg;
    logic [DATA_W-1:0]   rem_neg, quo_neg;

    twos_negate #(.W(2*DATA_W)) u_neg_prod (.a_i({acc_q, sh_q}), .y_o(prod_neg));
    twos_negate #(.W(DATA_W))   u_neg_rem  (.a_i(acc_q),         .y_o(rem_neg));
    twos_negate #(.W(DATA_W))   u_neg_quo  (.a_i(sh_q),          .y_o(quo_neg));

    // ALU drive and per-iteration next values. Outside ITER the ALU ports
    // sit at their idle values (ADD, 0, 0).
    assign rem_shift = {acc_q[DATA_W-2:0], sh_q[DATA_W-1]};

    always_comb begin
        alu_ctrl = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        if (state_q == MD_ITER) begin
            if (op_div) begin
                alu_ctrl = ALU_SUB;
                alu_a    = rem_shift;
                alu_b    = opb_q;
            end else begin
                alu_ctrl = ALU_ADD;
                alu_a    = acc_q;
                alu_b    = sh_q[0] ? opb_q : '0;
            end
        end
    end

    // Carry-out of a+b and borrow-out of a-b recovered from the MSBs only,
    // since the ALU exposes just the DATA_W-bit result.
    assign carry  = (alu_a[DATA_W-1] & alu_b[DATA_W-1])
                  | ((alu_a[DATA_W-1] | alu_b[DATA_W-1]) & ~alu_result[DATA_W-1]);
    assign borrow = (~alu_a[DATA_W-1] & alu_b[DATA_W-1])
                  | ((~alu_a[DATA_W-1] | alu_b[DATA_W-1]) & alu_result[DATA_W-1]);

    always_comb begin
        acc_d = acc_q;
        sh_d  = sh_q;
        if (op_div) begin
            // acc_q[MSB] is the bit shifted out of R'; when set, R' exceeds
            // the divisor regardless of the 32-bit borrow.
            if (acc_q[DATA_W-1] || !borrow) begin
                acc_d = alu_result;
                sh_d  = {sh_q[DATA_W-2:0], 1'b1};
            end else begin
                acc_d = rem_shift;
                sh_d  = {sh_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_d = {carry, alu_result[DATA_W-1:1]};
            sh_d  = {alu_result[0], sh_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            op_q    <= MD_MULTU;
            rs_q    <= '0;
            rt_q    <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        rs_q    <= rsdata;
                        rt_q    <= rtdata;
                        busy_q  <= 1'b1;
                        state_q <= MD_SIGN;
                    end
                end
                MD_SIGN: begin
                    negq_q <= op_signed & (rs_q[DATA_W-1] ^ rt_q[DATA_W-1]);
                    negr_q <= op_signed & rs_q[DATA_W-1];
                    div0_q <= (rt_q == '0);
                    cnt_q  <= '0;
                    acc_q  <= '0;
                    if (op_div) begin
                        sh_q  <= opnd_abs[0];
                        opb_q <= opnd_abs[1];
                    end else begin
                        sh_q  <= opnd_abs[1];
                        opb_q <= opnd_abs[0];
                    end
                    state_q <= MD_ITER;
                end
                MD_ITER: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    if (op_div) begin
                        hi_q <= negr_q ? rem_neg : acc_q;
                        // A zero divisor yields an all-ones quotient that
                        // must not be sign-corrected.
                        lo_q <= (negq_q && !div0_q) ? quo_neg : sh_q;
                    end else begin
                        {hi_q, lo_q} <= negq_q ? prod_neg : {acc_q, sh_q};
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= MD_DONE;
                end
                MD_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
